// File: rtl/mnist_bnn_pkg.sv
// Shared MNIST BNN constants and the top-level FSM state type.
// The pixel loader takes its default image geometry and the s_LOAD state from here.
package mnist_bnn_pkg;

    localparam int IMG_DIM   = 28;
    localparam int PIX_BUS_W = 8;
    localparam int PIX_BEATS = IMG_DIM * IMG_DIM / PIX_BUS_W;

    typedef enum logic [2:0] {
        s_IDLE,
        s_LOAD,
        s_LAYER_1,
        s_LAYER_2,
        s_OUTPUT
    } state_t;

endpackage

// File: rtl/pixel_loader_if.sv
// Valid/ready beat stream from the chip input pins into the pixel loader.
interface pixel_loader_if
    import mnist_bnn_pkg::*;
#(
    parameter int BUS_W = PIX_BUS_W
);

    logic             in_valid;
    logic [BUS_W-1:0] in_data;
    logic             in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/pixel_loader_pos.sv
// pix_pos_counter: raster row/col tracker that steps by BUS_W pixels per beat,
// and gives the row/col each bit of the current beat lands on.
module pix_pos_counter
    import mnist_bnn_pkg::*;
#(
    parameter int IMG_DIM = mnist_bnn_pkg::IMG_DIM,
    parameter int BUS_W   = PIX_BUS_W,
    localparam int POS_W  = $clog2(IMG_DIM)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_clear,
    input  logic                        i_step,
    output logic [POS_W-1:0]            o_row,
    output logic [POS_W-1:0]            o_col,
    output logic [BUS_W-1:0][POS_W-1:0] o_bitRow,
    output logic [BUS_W-1:0][POS_W-1:0] o_bitCol
);

    localparam logic [POS_W:0] DIM_X = (POS_W + 1)'(IMG_DIM);

    logic [POS_W-1:0] r_row;
    logic [POS_W-1:0] r_col;
    logic [POS_W:0]   w_colSum;
    logic [POS_W-1:0] w_nextRow;
    logic [POS_W-1:0] w_nextCol;

    // A beat never spans more than one row boundary, so one conditional subtract replaces a divider.
    always_comb begin
        w_colSum  = {1'b0, r_col} + (POS_W + 1)'(BUS_W);
        w_nextRow = r_row;
        w_nextCol = w_colSum[POS_W-1:0];
        if (w_colSum >= DIM_X) begin
            w_nextCol = POS_W'(w_colSum - DIM_X);
            w_nextRow = (r_row == POS_W'(IMG_DIM - 1)) ? '0 : r_row + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_step) begin
            r_row <= w_nextRow;
            r_col <= w_nextCol;
        end
    end

    always_comb begin
        logic [POS_W:0] w_sum;
        o_bitRow = '0;
        o_bitCol = '0;
        for (int i = 0; i < BUS_W; i++) begin
            w_sum       = {1'b0, r_col} + (POS_W + 1)'(i);
            o_bitRow[i] = r_row;
            o_bitCol[i] = w_sum[POS_W-1:0];
            if (w_sum >= DIM_X) begin
                o_bitRow[i] = r_row + 1'b1;
                o_bitCol[i] = POS_W'(w_sum - DIM_X);
            end
        end
    end

    assign o_row = r_row;
    assign o_col = r_col;

endmodule

// File: rtl/pixel_loader.sv
// pixel_loader: assembles the binary input image for layer 1 from a valid/ready beat stream.
// Optional macro PIXEL_CHECKSUM_EN adds an 8-bit running sum of accepted beats on o_checksum.
module pixel_loader
    import mnist_bnn_pkg::*;
#(
    parameter int IMG_DIM = mnist_bnn_pkg::IMG_DIM,
    parameter int BUS_W   = PIX_BUS_W
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  state_t                           i_state,
    pixel_loader_if.slave                    pix,
    output logic [IMG_DIM-1:0][IMG_DIM-1:0]  o_pixels,
    output logic                             o_done
`ifdef PIXEL_CHECKSUM_EN
    ,
    output logic [7:0]                       o_checksum
`endif
);

    localparam int BEATS = IMG_DIM * IMG_DIM / BUS_W;
    localparam int CNT_W = $clog2(BEATS + 1);
    localparam int POS_W = $clog2(IMG_DIM);

    typedef enum logic [1:0] {
        L_IDLE,
        L_LOAD,
        L_FULL
    } loadState_t;

    loadState_t                        r_state;
    loadState_t                        w_nextState;
    logic                              r_ready;
    logic                              w_nextReady;
    logic                              r_done;
    logic                              w_nextDone;
    logic                              w_clear;
    logic                              w_xfer;
    logic [CNT_W-1:0]                  r_beatCnt;
    logic [IMG_DIM-1:0][IMG_DIM-1:0]   r_pixels;
    logic [POS_W-1:0]                  w_curRow;
    logic [POS_W-1:0]                  w_curCol;
    logic [BUS_W-1:0][POS_W-1:0]       w_bitRow;
    logic [BUS_W-1:0][POS_W-1:0]       w_bitCol;
    logic                              w_unusedPos;

    always_comb begin
        w_nextState = r_state;
        w_nextReady = 1'b0;
        w_nextDone  = 1'b0;
        w_clear     = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            L_IDLE: begin
                if (i_state == s_LOAD) begin
                    w_nextState = L_LOAD;
                    w_nextReady = 1'b1;
                    w_clear     = 1'b1;
                end
            end
            L_LOAD: begin
                // Leaving s_LOAD mid-image aborts; the partial pixels stay until the next load overwrites them.
                if (i_state != s_LOAD) begin
                    w_nextState = L_IDLE;
                    w_clear     = 1'b1;
                end else begin
                    w_nextReady = 1'b1;
                    if (pix.in_valid && r_ready) begin
                        w_xfer = 1'b1;
                        if (r_beatCnt == CNT_W'(BEATS - 1)) begin
                            w_nextState = L_FULL;
                            w_nextReady = 1'b0;
                            w_nextDone  = 1'b1;
                        end
                    end
                end
            end
            L_FULL: begin
                if (i_state == s_LOAD) begin
                    w_nextDone = 1'b1;
                end else begin
                    w_nextState = L_IDLE;
                end
            end
            default: w_nextState = L_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= L_IDLE;
            r_ready   <= 1'b0;
            r_done    <= 1'b0;
            r_beatCnt <= '0;
        end else begin
            r_state <= w_nextState;
            r_ready <= w_nextReady;
            r_done  <= w_nextDone;
            if (w_clear) begin
                r_beatCnt <= '0;
            end else if (w_xfer) begin
                r_beatCnt <= r_beatCnt + 1'b1;
            end
        end
    end

    pix_pos_counter #(
        .IMG_DIM (IMG_DIM),
        .BUS_W   (BUS_W)
    ) u_pos (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (w_clear),
        .i_step   (w_xfer),
        .o_row    (w_curRow),
        .o_col    (w_curCol),
        .o_bitRow (w_bitRow),
        .o_bitCol (w_bitCol)
    );

    // The beat-start position is carried in the per-bit targets; it is kept on the tracker for observability.
    assign w_unusedPos = ^{w_curRow, w_curCol};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pixels <= '0;
        end else if (w_xfer) begin
            for (int i = 0; i < BUS_W; i++) begin
                r_pixels[w_bitRow[i]][w_bitCol[i]] <= pix.in_data[i];
            end
        end
    end

`ifdef PIXEL_CHECKSUM_EN
    logic [7:0] r_checksum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_checksum <= '0;
        end else if (r_state == L_IDLE && i_state == s_LOAD) begin
            r_checksum <= '0;
        end else if (w_xfer) begin
            r_checksum <= r_checksum + 8'(pix.in_data);
        end
    end

    assign o_checksum = r_checksum;
`endif

    assign pix.in_ready = r_ready;
    assign o_done       = r_done;
    assign o_pixels     = r_pixels;

endmodule

// File: tb/tb_pixel_loader.sv
// Scoreboard bench for pixel_loader: random beat streams against a raster-order image model.
// Build with PIXEL_CHECKSUM_EN defined to also check the running beat checksum.
module tb_pixel_loader;
    import mnist_bnn_pkg::*;

    localparam int DIM   = IMG_DIM;
    localparam int BW    = PIX_BUS_W;
    localparam int BEATS = PIX_BEATS;
    localparam int NPIX  = DIM * DIM;

    typedef logic [DIM-1:0][DIM-1:0] img_t;

    logic   clk;
    logic   rst_n;
    state_t state;
    img_t   pixels;
    logic   done;
`ifdef PIXEL_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    pixel_loader_if #(.BUS_W(BW)) pix();

    pixel_loader #(
        .IMG_DIM (DIM),
        .BUS_W   (BW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_state  (state),
        .pix      (pix),
        .o_pixels (pixels),
        .o_done   (done)
`ifdef PIXEL_CHECKSUM_EN
        ,
        .o_checksum (checksum)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          checks = 0;
    int          errors = 0;
    img_t        expQ[$];
    logic [7:0]  csQ[$];
    logic [BW-1:0] beatBuf[BEATS];
    int          loadXfers = 0;
    int          negCycle = 0;
    int          lastXferCycle = 0;
    img_t        lastImg;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkImage(input string name, input img_t actual, input img_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Raster order: pixel k is bit k%BW of beat k/BW, placed at row k/DIM, column k%DIM.
    function automatic img_t modelImage();
        img_t img = '0;
        for (int k = 0; k < NPIX; k++) begin
            img[k / DIM][k % DIM] = beatBuf[k / BW][k % BW];
        end
        return img;
    endfunction

    function automatic logic [7:0] modelChecksum();
        int s = 0;
        for (int b = 0; b < BEATS; b++) begin
            s = (s + int'(beatBuf[b]) % 256) % 256;
        end
        return 8'(s);
    endfunction

    // Scoreboard monitor: every rising done is matched against the oldest queued image.
    initial begin : monitor
        logic prevDone;
        img_t expImg;
        logic [7:0] expCs;
        prevDone = 1'b0;
        forever begin
            @(negedge clk);
            negCycle++;
            if (rst_n === 1'b1 && done === 1'b1 && !prevDone) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_unexpected_done: got done=1, expected no completion");
                end else begin
                    expImg = expQ.pop_front();
                    checkImage("sb_pixels", pixels, expImg);
                    checkOutput("sb_xfer_count", loadXfers, BEATS);
                    checkOutput("sb_done_latency", negCycle - lastXferCycle, 1);
                    checkOutput("sb_ready_at_done", pix.in_ready, 0);
`ifdef PIXEL_CHECKSUM_EN
                    expCs = csQ.pop_front();
                    checkOutput("sb_checksum", checksum, expCs);
`else
                    expCs = 8'h00;
`endif
                end
            end
            if (rst_n !== 1'b1 || state != s_LOAD) begin
                loadXfers = 0;
            end else if (pix.in_valid === 1'b1 && pix.in_ready === 1'b1) begin
                loadXfers++;
                lastXferCycle = negCycle;
            end
            prevDone = (done === 1'b1);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached after %0d checks", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    // Offers one beat after a random idle gap and holds it until the loader accepts it.
    task automatic applyStimulus(input logic [BW-1:0] data, input int gapMax);
        int gap;
        int waitCnt;
        logic accepted;
        gap = (gapMax > 0) ? int'($urandom_range(gapMax, 0)) : 0;
        pix.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        pix.in_valid = 1'b1;
        pix.in_data  = data;
        accepted = 1'b0;
        waitCnt  = 0;
        while (!accepted && waitCnt < 50) begin
            @(negedge clk);
            accepted = (pix.in_ready === 1'b1);
            @(posedge clk);
            #1;
            waitCnt++;
        end
        pix.in_valid = 1'b0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_accept: got no in_ready within 50 cycles, expected acceptance");
        end
    endtask

    task automatic loadImage(input int gapMax);
        state = s_LOAD;
        expQ.push_back(modelImage());
        csQ.push_back(modelChecksum());
        for (int b = 0; b < BEATS; b++) begin
            applyStimulus(beatBuf[b], gapMax);
        end
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 20);
        if (done !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: got done=%b after 20 cycles, expected 1", name, done);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic leaveLoad(input string name, input img_t expImg);
        state = s_LAYER_1;
        @(posedge clk);
        #1;
        state = s_IDLE;
        @(negedge clk);
        checkOutput({name, "_done"}, done, 0);
        checkOutput({name, "_ready"}, pix.in_ready, 0);
        checkImage({name, "_pixels"}, pixels, expImg);
        @(posedge clk);
        #1;
    endtask

    initial begin
        img_t expImg;
        rst_n        = 1'b0;
        state        = s_IDLE;
        pix.in_valid = 1'b0;
        pix.in_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_ready", pix.in_ready, 0);
        checkImage("reset_pixels", pixels, '0);
`ifdef PIXEL_CHECKSUM_EN
        checkOutput("reset_checksum", checksum, 0);
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] back-to-back load of 0x55 beats");
        for (int b = 0; b < BEATS; b++) beatBuf[b] = {(BW / 2){2'b01}};
        loadImage(0);
        waitDone("full_load_done");
        expImg = '0;
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                expImg[r][c] = ((r * DIM + c) % 2 == 0);
        checkImage("parity_pixels", pixels, expImg);
        checkOutput("full_done_held", done, 1);
        leaveLoad("full_leave", expImg);

        $display("[TB] same image with back-pressure gaps, then an extra beat");
        loadImage(3);
        waitDone("bp_load_done");
        pix.in_valid = 1'b1;
        pix.in_data  = ~beatBuf[0];
        repeat (5) @(negedge clk);
        checkOutput("extra_beat_ready", pix.in_ready, 0);
        checkOutput("extra_beat_xfers", loadXfers, BEATS);
        checkImage("extra_beat_pixels", pixels, expImg);
        @(posedge clk);
        #1;
        pix.in_valid = 1'b0;
        leaveLoad("bp_leave", expImg);

        $display("[TB] row straddle beat");
        for (int b = 0; b < BEATS; b++) beatBuf[b] = '0;
        beatBuf[3] = BW'(8'hF0);
        loadImage(1);
        waitDone("straddle_done");
        expImg = '0;
        for (int c = 0; c < 4; c++) expImg[1][c] = 1'b1;
        checkImage("straddle_pixels", pixels, expImg);
        leaveLoad("straddle_leave", expImg);

        $display("[TB] random images");
        for (int t = 0; t < 2; t++) begin
            for (int b = 0; b < BEATS; b++) beatBuf[b] = BW'($urandom);
            loadImage(3);
            waitDone("random_done");
            lastImg = modelImage();
            leaveLoad("random_leave", lastImg);
        end

        $display("[TB] abort after 40 beats of all ones, then reload zeros");
        state = s_LOAD;
        for (int b = 0; b < 40; b++) applyStimulus('1, 0);
        expImg = lastImg;
        for (int k = 0; k < 40 * BW; k++) expImg[k / DIM][k % DIM] = 1'b1;
        leaveLoad("abort", expImg);
        for (int b = 0; b < BEATS; b++) beatBuf[b] = '0;
        loadImage(1);
        waitDone("reload_done");
        checkImage("reload_pixels", pixels, '0);
        leaveLoad("reload_leave", '0);

        $display("[TB] reset in the middle of a load");
        state = s_LOAD;
        for (int b = 0; b < 50; b++) applyStimulus('1, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        state = s_IDLE;
        @(negedge clk);
        checkImage("midreset_pixels", pixels, '0);
        checkOutput("midreset_done", done, 0);
        checkOutput("midreset_ready", pix.in_ready, 0);
`ifdef PIXEL_CHECKSUM_EN
        checkOutput("midreset_checksum", checksum, 0);
`endif
        pix.in_valid = 1'b1;
        pix.in_data  = '1;
        repeat (4) @(negedge clk);
        state = s_LAYER_1;
        repeat (4) @(negedge clk);
        checkImage("idle_beats_pixels", pixels, '0);
        checkOutput("idle_beats_ready", pix.in_ready, 0);
        checkOutput("idle_beats_done", done, 0);
        @(posedge clk);
        #1;
        pix.in_valid = 1'b0;
        state = s_IDLE;

        $display("[TB] ramp image n=0..%0d", BEATS - 1);
        for (int b = 0; b < BEATS; b++) beatBuf[b] = BW'(b);
        loadImage(1);
        waitDone("ramp_done");
`ifdef PIXEL_CHECKSUM_EN
        checkOutput("ramp_checksum", checksum, 8'h91);
`endif
        leaveLoad("ramp_leave", modelImage());
`ifdef PIXEL_CHECKSUM_EN
        checkOutput("ramp_checksum_held", checksum, 8'h91);
`endif
        state = s_LOAD;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reentry_ready", pix.in_ready, 1);
`ifdef PIXEL_CHECKSUM_EN
        checkOutput("reentry_checksum", checksum, 0);
`endif
        @(posedge clk);
        #1;
        state = s_IDLE;
        repeat (2) @(posedge clk);
        #1;

        checkOutput("sb_drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
